seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode, NUM_DIGITS-digit seven-segment display. It holds a double-buffered BCD display value and steps through the digits one at a time. For each digit it drives the shared BCD-to-segment decoder's 4-bit `bcd` input plus that digit's active-low anode enable. A guard interval blanks the anodes around every digit change so the previous digit never ghosts. The block sits between the number-producing logic and the combinational seven-segment decoder.

---
 rtl/seg_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// seven-segment display. Holds a double-buffered BCD value, steps through
// the digits one slot at a time and blanks the anodes for a guard interval
// at the start of every slot so the previous digit never ghosts.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    st_blank,
    st_show
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [IW-1:0]   idx_reg, idx_next;

  logic [VW-1:0]         shadow_val_reg;
  logic [NUM_DIGITS-1:0] shadow_dp_reg;
  logic [VW-1:0]         active_val_reg, active_val_next;
  logic [NUM_DIGITS-1:0] active_dp_reg, active_dp_next;
  logic                  pending_reg, pending_next;

  // Set by reset so the first slot after reset gets its digit loaded,
  // since that slot does not begin with a slot-end edge.
  logic                  fresh_reg;

  logic [3:0]            bcd_reg, bcd_next;
  logic                  dp_reg, dp_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic                  frame_done_reg, frame_done_next;

  logic slot_end;
  logic wrap;
  logic blank_digit;

  // zero_above[k]: active digits k..NUM_DIGITS-1 are all zero with no dp set
  logic [NUM_DIGITS:0] zero_above;

  assign slot_end = (cnt_reg == CNT_LAST);
  assign wrap     = slot_end && (idx_reg == IDX_LAST);

  // FSM state register with slot counter and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= st_blank;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state: guard interval, then show, restart at every slot end
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    idx_next   = idx_reg;
    if (slot_end) begin
      cnt_next   = '0;
      idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
      state_next = (BLANK_CYCLES == 0) ? st_show : st_blank;
    end else if (state_reg == st_blank &&
                 (BLANK_CYCLES == 0 || cnt_reg == BLANK_LAST)) begin
      state_next = st_show;
    end
  end

  // Double buffer: loads park in the shadow and are promoted only at a
  // frame wrap; a load on the wrap cycle itself goes straight to active.
  always_comb begin
    active_val_next = active_val_reg;
    active_dp_next  = active_dp_reg;
    pending_next    = pending_reg;
    if (wrap) begin
      pending_next = 1'b0;
      if (load) begin
        active_val_next = value;
        active_dp_next  = dp_in;
      end else if (pending_reg) begin
        active_val_next = shadow_val_reg;
        active_dp_next  = shadow_dp_reg;
      end
    end else if (load) begin
      pending_next = 1'b1;
    end
  end

  assign zero_above[NUM_DIGITS] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lead_zero
      assign zero_above[gi] = zero_above[gi+1] &&
                              (active_val_next[4*gi +: 4] == 4'h0) &&
                              !active_dp_next[gi];
    end
  endgenerate

  assign blank_digit = lzb && (idx_next != '0) && zero_above[idx_next];

  // Output next values: digit data changes only at slot boundaries,
  // anodes follow the next FSM state so they are one-hot-low or all off.
  always_comb begin
    bcd_next        = bcd_reg;
    dp_next         = dp_reg;
    an_next         = '1;
    frame_done_next = (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
    if (slot_end || fresh_reg) begin
      if (blank_digit) begin
        bcd_next = 4'hF;
        dp_next  = 1'b0;
      end else begin
        bcd_next = active_val_next[{idx_next, 2'b00} +: 4];
        dp_next  = active_dp_next[idx_next];
      end
    end
    if (state_next == st_show) begin
      an_next[idx_next] = 1'b0;
    end
  end

  // Buffers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val_reg <= '0;
      shadow_dp_reg  <= '0;
      active_val_reg <= '0;
      active_dp_reg  <= '0;
      pending_reg    <= 1'b0;
      fresh_reg      <= 1'b1;
      bcd_reg        <= 4'hF;
      dp_reg         <= 1'b0;
      an_reg         <= '1;
      frame_done_reg <= 1'b0;
    end else begin
      if (load) begin
        shadow_val_reg <= value;
        shadow_dp_reg  <= dp_in;
      end
      active_val_reg <= active_val_next;
      active_dp_reg  <= active_dp_next;
      pending_reg    <= pending_next;
      fresh_reg      <= 1'b0;
      bcd_reg        <= bcd_next;
      dp_reg         <= dp_next;
      an_reg         <= an_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign bcd        = bcd_reg;
  assign dp         = dp_reg;
  assign an         = an_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with a cycle-level
// reference model (slot/frame arithmetic on a cycle counter) checked every
// cycle, plus literal spot checks. A second instance with no guard interval
// shares all inputs.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = ND * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        lzb = 1'b0;

  logic [3:0]  bcd, bcd2;
  logic [3:0]  an, an2;
  logic        dp, dp2;
  logic        frame_done, frame_done2;

  int total = 0;
  int bad = 0;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .lzb(lzb),
    .bcd(bcd), .an(an), .dp(dp), .frame_done(frame_done)
  );

  seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(0)) dut_nb (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .lzb(lzb),
    .bcd(bcd2), .an(an2), .dp(dp2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, req);
    end
  endtask

  // Reference model: t counts cycles since reset release (cycle 0 shows
  // reset values). Frame content is latched at each frame wrap from the
  // latest load; lzb is sampled at the edge that starts a slot.
  int          t = 0;
  bit          mok = 1'b0;
  logic [15:0] lat_v = '0, frm_v = '0;
  logic [3:0]  lat_dp = '0, frm_dp = '0;
  bit          lat_ok = 1'b0;
  logic [3:0]  e_bcd = 4'hF, e_an = 4'hF, e_an2 = 4'hF;
  logic        e_dp = 1'b0, e_fd = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      mok = 1'b1;
      lat_ok = 1'b0;
      frm_v = '0;
      frm_dp = '0;
      e_bcd = 4'hF;
      e_dp = 1'b0;
    end else if (mok) begin
      if (load) begin
        lat_v = value;
        lat_dp = dp_in;
        lat_ok = 1'b1;
      end
      if (t % FR == FR - 1 && lat_ok) begin
        frm_v = lat_v;
        frm_dp = lat_dp;
        lat_ok = 1'b0;
      end
      if (t == 0 || t % RD == RD - 1) begin
        int k;
        k = ((t + 1) / RD) % ND;
        if (lzb && k > 0 && (frm_v >> (4 * k)) == 16'h0 && (frm_dp >> k) == 4'h0) begin
          e_bcd = 4'hF;
          e_dp = 1'b0;
        end else begin
          e_bcd = frm_v[4*k +: 4];
          e_dp = frm_dp[k];
        end
      end
      t = t + 1;
    end
    begin
      int c, k;
      c = t % RD;
      k = (t / RD) % ND;
      e_an  = (t == 0 || c < BC) ? 4'hF : ~(4'b0001 << k);
      e_an2 = (t == 0) ? 4'hF : ~(4'b0001 << k);
      e_fd  = (t % FR == FR - 1);
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (mok) begin
      chk("an",          {12'h0, an},           {12'h0, e_an});
      chk("bcd",         {12'h0, bcd},          {12'h0, e_bcd});
      chk("dp",          {15'h0, dp},           {15'h0, e_dp});
      chk("frame_done",  {15'h0, frame_done},   {15'h0, e_fd});
      chk("an_nb",       {12'h0, an2},          {12'h0, e_an2});
      chk("bcd_nb",      {12'h0, bcd2},         {12'h0, e_bcd});
      chk("dp_nb",       {15'h0, dp2},          {15'h0, e_dp});
      chk("frame_done_nb", {15'h0, frame_done2}, {15'h0, e_fd});
    end
  end

  task automatic goto(input int target);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (t != target && n < 1000);
    if (t != target) begin
      $display("FAIL goto_timeout t=%0d actual=%0d required=%0d", t, t, target);
      $fatal(1, "cycle budget exceeded");
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load = 1'b1;
    $display("load t=%0d value=%h dp=%b", t, v, d);
  endtask

  initial begin
    // Reset for two edges, release in cycle 0
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset released t=%0d", t);
    #4;
    chk("lit_reset_an",  {12'h0, an},  16'h000F);
    chk("lit_reset_bcd", {12'h0, bcd}, 16'h000F);
    goto(2); #4;
    chk("lit_show0_an",  {12'h0, an},  16'h000E);
    chk("lit_show0_bcd", {12'h0, bcd}, 16'h0000);

    // Mid-frame load is held until the next wrap
    goto(10); do_load(16'h1234, 4'b0100);
    goto(11); load = 1'b0;
    goto(20); #4;
    chk("lit_old_frame_bcd", {12'h0, bcd}, 16'h0000);
    goto(34); #4;
    chk("lit_1234_d0_an",  {12'h0, an},  16'h000E);
    chk("lit_1234_d0_bcd", {12'h0, bcd}, 16'h0004);
    goto(50); #4;
    chk("lit_1234_d2_an",  {12'h0, an},  16'h000B);
    chk("lit_1234_d2_bcd", {12'h0, bcd}, 16'h0002);
    chk("lit_1234_d2_dp",  {15'h0, dp},  16'h0001);
    goto(58); #4;
    chk("lit_1234_d3_bcd", {12'h0, bcd}, 16'h0001);

    // Two loads in one frame: last wins
    goto(70); do_load(16'h5678, 4'b0000);
    goto(71); load = 1'b0;
    goto(80); do_load(16'h9012, 4'b0000);
    goto(81); load = 1'b0;
    goto(98); #4;
    chk("lit_9012_d0_bcd", {12'h0, bcd}, 16'h0002);
    goto(122); #4;
    chk("lit_9012_d3_bcd", {12'h0, bcd}, 16'h0009);

    // Load exactly on the wrap cycle
    goto(127); do_load(16'h4321, 4'b0001);
    goto(128); load = 1'b0;
    goto(130); #4;
    chk("lit_wrapload_bcd", {12'h0, bcd}, 16'h0001);
    chk("lit_wrapload_dp",  {15'h0, dp},  16'h0001);

    // Leading-zero blanking
    goto(140); do_load(16'h0050, 4'b0000);
    goto(141); load = 1'b0;
    goto(150); lzb = 1'b1;
    $display("lzb=1 t=%0d", t);
    goto(170); #4;
    chk("lit_lzb_d1_bcd", {12'h0, bcd}, 16'h0005);
    goto(178); #4;
    chk("lit_lzb_d2_bcd", {12'h0, bcd}, 16'h000F);
    chk("lit_lzb_d2_an",  {12'h0, an},  16'h000B);
    goto(180); do_load(16'h0000, 4'b0000);
    goto(181); load = 1'b0;
    goto(194); #4;
    chk("lit_lzb0_d0_bcd", {12'h0, bcd}, 16'h0000);
    goto(202); #4;
    chk("lit_lzb0_d1_bcd", {12'h0, bcd}, 16'h000F);
    goto(210); do_load(16'h0000, 4'b0010);
    goto(211); load = 1'b0;
    goto(234); #4;
    chk("lit_lzbdp_d1_bcd", {12'h0, bcd}, 16'h0000);
    chk("lit_lzbdp_d1_dp",  {15'h0, dp},  16'h0001);
    goto(242); #4;
    chk("lit_lzbdp_d2_bcd", {12'h0, bcd}, 16'h000F);
    goto(250); lzb = 1'b0;
    $display("lzb=0 t=%0d", t);

    // Pending load discarded by a reset during digit 2's show phase
    goto(266); do_load(16'h7777, 4'b1111);
    goto(267); load = 1'b0;
    goto(275); rst = 1'b1;
    $display("reset pulse t=%0d", t);
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
    chk("lit_midrst_an",  {12'h0, an},  16'h000F);
    chk("lit_midrst_bcd", {12'h0, bcd}, 16'h000F);
    chk("lit_midrst_fd",  {15'h0, frame_done}, 16'h0000);
    goto(31); #4;
    chk("lit_midrst_fd31", {15'h0, frame_done}, 16'h0001);
    goto(34); #4;
    chk("lit_midrst_d0_bcd", {12'h0, bcd}, 16'h0000);
    chk("lit_midrst_d0_dp",  {15'h0, dp},  16'h0000);
    goto(42); #4;
    chk("lit_midrst_d1_bcd", {12'h0, bcd}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
